// File: rtl/bsg_mem_bist_pkg.sv
// bsg_mem_bist_pkg
// Shared types and constants for the single-port March C- BIST engine.
//   march_elem_e : march element index E0..E5 (also reported as fail_elem_o)
//   bist_state_e : top-level sequencer states
//   march_op_t   : per-element op descriptor (direction, read/write backgrounds)
//   MARCH_OPS    : descriptor table indexed by march_elem_e
package bsg_mem_bist_pkg;

  typedef enum logic [2:0] {
    ELEM_E0 = 3'd0,
    ELEM_E1 = 3'd1,
    ELEM_E2 = 3'd2,
    ELEM_E3 = 3'd3,
    ELEM_E4 = 3'd4,
    ELEM_E5 = 3'd5
  } march_elem_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // down      : 1 = walk addresses els_p-1 -> 0
  // has_read  : element starts each address with a read of rd_bg
  // rd_bg     : expected background of that read (replicated to full width)
  // has_write : element writes wr_bg to each address (after the read, if any)
  // wr_bg     : background written
  typedef struct packed {
    logic down;
    logic has_read;
    logic rd_bg;
    logic has_write;
    logic wr_bg;
  } march_op_t;

  localparam march_elem_e LAST_ELEM = ELEM_E5;

  // March C-: E0 up w0 / E1 up (r0,w1) / E2 up (r1,w0) /
  //           E3 down (r0,w1) / E4 down (r1,w0) / E5 up r0.
  // Entries 6 and 7 are unreachable padding so any 3-bit index is in range.
  localparam march_op_t MARCH_OPS [8] = '{
    '{down: 1'b0, has_read: 1'b0, rd_bg: 1'b0, has_write: 1'b1, wr_bg: 1'b0},
    '{down: 1'b0, has_read: 1'b1, rd_bg: 1'b0, has_write: 1'b1, wr_bg: 1'b1},
    '{down: 1'b0, has_read: 1'b1, rd_bg: 1'b1, has_write: 1'b1, wr_bg: 1'b0},
    '{down: 1'b1, has_read: 1'b1, rd_bg: 1'b0, has_write: 1'b1, wr_bg: 1'b1},
    '{down: 1'b1, has_read: 1'b1, rd_bg: 1'b1, has_write: 1'b1, wr_bg: 1'b0},
    '{down: 1'b0, has_read: 1'b1, rd_bg: 1'b0, has_write: 1'b0, wr_bg: 1'b0},
    '{down: 1'b0, has_read: 1'b0, rd_bg: 1'b0, has_write: 1'b0, wr_bg: 1'b0},
    '{down: 1'b0, has_read: 1'b0, rd_bg: 1'b0, has_write: 1'b0, wr_bg: 1'b0}
  };

endpackage

// File: rtl/bsg_mem_bist_addr_gen.sv
// bsg_mem_bist_addr_gen
// Up/down address counter for the march sequencer. The register is the
// address currently presented to the memory.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   load_i           : load start address (els_p-1 if load_down_i, else 0)
//   load_down_i      : direction of the element being loaded
//   step_i           : advance one address in direction down_i
//   down_i           : direction of the element currently running
//   addr_o           : current address
//   last_o           : addr_o is the final address for direction down_i
module bsg_mem_bist_addr_gen
  #(parameter int els_p         = 512,
    parameter int addr_width_lp = $clog2(els_p))
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     load_i,
   input  logic                     load_down_i,
   input  logic                     step_i,
   input  logic                     down_i,
   output logic [addr_width_lp-1:0] addr_o,
   output logic                     last_o);

  // Terminal is els_p-1, not 2^n-1, so non-power-of-two depths work.
  localparam logic [addr_width_lp-1:0] max_addr_lp = addr_width_lp'(els_p - 1);
  localparam logic [addr_width_lp-1:0] one_lp      = addr_width_lp'(1);

  logic [addr_width_lp-1:0] addr_q, addr_d;
  logic                     at_max, at_zero;

  assign at_max  = (addr_q == max_addr_lp);
  assign at_zero = (addr_q == '0);

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? max_addr_lp : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - one_lp) : (addr_q + one_lp);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = down_i ? at_zero : at_max;

endmodule

// File: rtl/bsg_mem_1rw_march_bist.sv
// bsg_mem_1rw_march_bist
// March C- built-in self-test initiator for a single-port 1rw memory with
// one-cycle synchronous read latency. A start pulse in IDLE/DONE runs all
// six march elements over addresses 0..els_p-1, one op per cycle, and
// reports pass/fail plus the first failing (address, element).
//   clk_i, reset_n_i    : clock, asynchronous active-low reset
//   start_i             : start request, honoured only in IDLE or DONE
//   busy_o              : high during RUN and DRAIN
//   done_o              : high in DONE, held until the next accepted start
//   pass_o              : valid with done_o, 1 = no mismatch observed
//   fail_addr_o/elem_o  : location of the first mismatch
//   mem_v_o .. mem_w_mask_o : registered memory request port
//   mem_data_i          : read data, valid the cycle after a read
module bsg_mem_1rw_march_bist
  import bsg_mem_bist_pkg::*;
  #(parameter int width_p       = 64,
    parameter int els_p         = 512,
    parameter int addr_width_lp = $clog2(els_p))
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     pass_o,
   output logic [addr_width_lp-1:0] fail_addr_o,
   output logic [2:0]               fail_elem_o,
   output logic                     mem_v_o,
   output logic                     mem_w_o,
   output logic [addr_width_lp-1:0] mem_addr_o,
   output logic [width_p-1:0]       mem_data_o,
   output logic [width_p-1:0]       mem_w_mask_o,
   input  logic [width_p-1:0]       mem_data_i);

  // Sequencer state. elem_q/phase_q/address describe the op currently on
  // the memory port; phase_q=1 marks the write half of a read-write pair.
  bist_state_e state_q, state_d;
  march_elem_e elem_q, elem_d, elem_nxt;
  logic        phase_q, phase_d;

  logic        start_accept;
  logic        cur_is_read;
  logic        addr_done;

  logic        gen_load, gen_load_down, gen_step, gen_down, gen_last;
  logic [addr_width_lp-1:0] gen_addr;

  // Registered memory request (address comes from the generator register).
  logic               mem_v_q, mem_v_d;
  logic               mem_w_q, mem_w_d;
  logic [width_p-1:0] mem_data_q, mem_data_d;
  logic [width_p-1:0] mem_mask_q, mem_mask_d;

  // Compare pipeline: what the read on the port this cycle expects.
  logic                     cmp_v_q, cmp_v_d;
  logic                     cmp_bg_q, cmp_bg_d;
  march_elem_e              cmp_elem_q, cmp_elem_d;
  logic [addr_width_lp-1:0] cmp_addr_q, cmp_addr_d;
  logic                     mismatch;

  // Sticky result and first-failure capture.
  logic                     fail_q, fail_d;
  logic [addr_width_lp-1:0] fail_addr_q, fail_addr_d;
  march_elem_e              fail_elem_q, fail_elem_d;
  logic                     pass_q, pass_d;

  assign start_accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign elem_nxt     = march_elem_e'(elem_q + 3'd1);
  assign gen_down     = MARCH_OPS[elem_q].down;
  assign cur_is_read  = MARCH_OPS[elem_q].has_read && !phase_q;
  // An address is finished unless we are on the read half of a read-write pair.
  assign addr_done    = !(cur_is_read && MARCH_OPS[elem_q].has_write);

  bsg_mem_bist_addr_gen #(
    .els_p         (els_p),
    .addr_width_lp (addr_width_lp)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .load_i      (gen_load),
    .load_down_i (gen_load_down),
    .step_i      (gen_step),
    .down_i      (gen_down),
    .addr_o      (gen_addr),
    .last_o      (gen_last)
  );

  // Next-state and next memory request. The request registers are loaded
  // from the *next* op so that the port is fully registered with no bubble.
  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    phase_d       = phase_q;
    gen_load      = 1'b0;
    gen_load_down = 1'b0;
    gen_step      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_accept) begin
          state_d       = ST_RUN;
          elem_d        = ELEM_E0;
          phase_d       = 1'b0;
          gen_load      = 1'b1;
          gen_load_down = MARCH_OPS[ELEM_E0].down;
        end
      end
      ST_RUN: begin
        if (!addr_done) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!gen_last) begin
            gen_step = 1'b1;
          end else if (elem_q == LAST_ELEM) begin
            state_d = ST_DRAIN;
          end else begin
            elem_d        = elem_nxt;
            gen_load      = 1'b1;
            gen_load_down = MARCH_OPS[elem_nxt].down;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_v_d    = (state_d == ST_RUN);
    mem_w_d    = mem_v_d && (!MARCH_OPS[elem_d].has_read || phase_d);
    mem_data_d = (mem_w_d && MARCH_OPS[elem_d].wr_bg) ? '1 : '0;
    mem_mask_d = mem_w_d ? '1 : '0;
  end

  // Capture what the read now on the port should return next cycle.
  always_comb begin
    cmp_v_d    = (state_q == ST_RUN) && cur_is_read;
    cmp_bg_d   = MARCH_OPS[elem_q].rd_bg;
    cmp_elem_d = elem_q;
    cmp_addr_d = gen_addr;
  end

  assign mismatch = cmp_v_q && (mem_data_i != {width_p{cmp_bg_q}});

  // The DRAIN cycle still carries the final compare, so pass folds it in.
  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    pass_d      = pass_q;
    if (start_accept) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = ELEM_E0;
      pass_d      = 1'b0;
    end else begin
      if (mismatch && !fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
      if (state_q == ST_DRAIN) begin
        pass_d = !(fail_q || mismatch);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      elem_q      <= ELEM_E0;
      phase_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_data_q  <= '0;
      mem_mask_q  <= '0;
      cmp_v_q     <= 1'b0;
      cmp_bg_q    <= 1'b0;
      cmp_elem_q  <= ELEM_E0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= ELEM_E0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      mem_v_q     <= mem_v_d;
      mem_w_q     <= mem_w_d;
      mem_data_q  <= mem_data_d;
      mem_mask_q  <= mem_mask_d;
      cmp_v_q     <= cmp_v_d;
      cmp_bg_q    <= cmp_bg_d;
      cmp_elem_q  <= cmp_elem_d;
      cmp_addr_q  <= cmp_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      pass_q      <= pass_d;
    end
  end

  assign busy_o       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);
  assign pass_o       = pass_q;
  assign fail_addr_o  = fail_addr_q;
  assign fail_elem_o  = fail_elem_q;
  assign mem_v_o      = mem_v_q;
  assign mem_w_o      = mem_w_q;
  assign mem_addr_o   = gen_addr;
  assign mem_data_o   = mem_data_q;
  assign mem_w_mask_o = mem_mask_q;

endmodule

// File: tb/tb_bsg_mem_1rw_march_bist.sv
// tb_bsg_mem_1rw_march_bist
// Two BIST instances (16x8 and 6x8) each driving a behavioural 1rw memory
// with one-cycle read latency. The 16-entry memory can inject a stuck-at-0
// bit or an address alias. Expected memory ops are queued at start and
// popped one per RUN cycle.
module tb_bsg_mem_1rw_march_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, sel;
  int   fault;

  logic       busy16, done16, pass16, v16, w16;
  logic [3:0] fa16, a16;
  logic [2:0] fe16;
  logic [7:0] d16, m16, rd16;

  logic       busy6, done6, pass6, v6, w6;
  logic [2:0] fa6, a6, fe6;
  logic [7:0] d6, m6, rd6;

  bsg_mem_1rw_march_bist #(.width_p(8), .els_p(16)) dut16 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start && !sel),
    .busy_o(busy16), .done_o(done16), .pass_o(pass16),
    .fail_addr_o(fa16), .fail_elem_o(fe16),
    .mem_v_o(v16), .mem_w_o(w16), .mem_addr_o(a16),
    .mem_data_o(d16), .mem_w_mask_o(m16), .mem_data_i(rd16));

  bsg_mem_1rw_march_bist #(.width_p(8), .els_p(6)) dut6 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start && sel),
    .busy_o(busy6), .done_o(done6), .pass_o(pass6),
    .fail_addr_o(fa6), .fail_elem_o(fe6),
    .mem_v_o(v6), .mem_w_o(w6), .mem_addr_o(a6),
    .mem_data_o(d6), .mem_w_mask_o(m6), .mem_data_i(rd6));

  // Memory models. fault 1: bit 3 of address 5 stuck at 0.
  // fault 2: address 9 decodes onto address 2.
  logic [7:0] mem16 [16];
  logic [7:0] mem6 [6];

  always @(posedge clk) begin : model16
    int         ea;
    logic [7:0] rv;
    if (v16) begin
      ea = (fault == 2 && a16 == 4'd9) ? 2 : int'(a16);
      if (w16) begin
        mem16[ea] <= d16;
      end else begin
        rv = mem16[ea];
        if (fault == 1 && a16 == 4'd5) rv[3] = 1'b0;
        rd16 <= rv;
      end
    end
  end

  int bad6 = 0;
  always @(posedge clk) begin : model6
    if (v6) begin
      if (a6 > 3'd5) bad6 <= bad6 + 1;
      else if (w6) mem6[a6] <= d6;
      else rd6 <= mem6[a6];
    end
  end

  // Observed outputs of the selected instance.
  logic       o_busy, o_done, o_pass, o_v, o_w;
  logic [3:0] o_addr, o_fa;
  logic [2:0] o_fe;
  logic [7:0] o_data, o_mask;
  assign o_busy = sel ? busy6 : busy16;
  assign o_done = sel ? done6 : done16;
  assign o_pass = sel ? pass6 : pass16;
  assign o_v    = sel ? v6 : v16;
  assign o_w    = sel ? w6 : w16;
  assign o_addr = sel ? {1'b0, a6} : a16;
  assign o_fa   = sel ? {1'b0, fa6} : fa16;
  assign o_fe   = sel ? fe6 : fe16;
  assign o_data = sel ? d6 : d16;
  assign o_mask = sel ? m6 : m16;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // March C- as a table: -1 = no read / no write in that element.
  typedef struct {
    bit w;
    int addr;
    int bg;
  } op_t;
  op_t sb[$];
  int  rd_tab [6] = '{-1, 0, 1, 0, 1, 0};
  int  wr_tab [6] = '{0, 1, 0, 1, 0, -1};
  bit  dn_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic build(input int n);
    sb.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        int a;
        a = dn_tab[e] ? (n - 1 - i) : i;
        if (rd_tab[e] >= 0) sb.push_back('{1'b0, a, rd_tab[e]});
        if (wr_tab[e] >= 0) sb.push_back('{1'b1, a, wr_tab[e]});
      end
    end
  endtask

  // Called #1 after a clock edge. Pulses start (sampled at edge 0) and
  // checks every cycle from 1 through 10n+2.
  task automatic run_test(input bit s, input int n, input bit exp_pass,
                          input int exp_fa, input int exp_fe, input bit glitch40);
    op_t        e;
    logic [7:0] bgv;
    sel = s;
    build(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_clears", {o_done, o_pass, o_busy, o_fa, o_fe}, {3'b001, 7'b0});
    for (int c = 1; c <= 10 * n + 1; c++) begin
      if (c <= 10 * n) begin
        e   = sb.pop_front();
        bgv = (e.bg != 0) ? 8'hFF : 8'h00;
        chk($sformatf("op_c%0d", c),
            {o_v, o_busy, o_w, o_addr, o_mask, (e.w ? o_data : 8'h00)},
            {1'b1, 1'b1, e.w, 4'(e.addr), (e.w ? 8'hFF : 8'h00), (e.w ? bgv : 8'h00)});
      end else begin
        chk("drain", {o_v, o_busy, o_done}, 3'b010);
      end
      start = glitch40 && (c == 40);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk($sformatf("done_c%0d", 10 * n + 2), {o_done, o_busy, o_v}, 3'b100);
    chk("pass", o_pass, exp_pass);
    if (!exp_pass) chk("fail_loc", {o_fa, o_fe}, {4'(exp_fa), 3'(exp_fe)});
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", {o_done, o_pass}, {1'b1, exp_pass});
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    sel     = 1'b0;
    fault   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", {o_busy, o_done, o_pass, o_fa, o_fe}, 10'h0);
    chk("reset_mem", {o_v, o_w, o_addr, o_data, o_mask}, 22'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_status", {o_busy, o_done, o_pass, o_v}, 4'h0);

    // Clean 16x8: 160 ops, done in cycle 162, pass.
    run_test(1'b0, 16, 1'b1, 0, 0, 1'b0);

    // Stuck-at-0 bit 3 @5, with an ignored start in cycle 40; rerun from DONE.
    fault = 1;
    run_test(1'b0, 16, 1'b0, 5, 2, 1'b1);

    // Alias 9 -> 2: first mismatch is the r0 of address 9 in E1.
    fault = 2;
    run_test(1'b0, 16, 1'b0, 9, 1, 1'b0);

    // Non-power-of-two depth: 6 words, done in cycle 62.
    fault = 0;
    run_test(1'b1, 6, 1'b1, 0, 0, 1'b0);
    chk("els6_addr_range", bad6, 0);

    // Asynchronous reset in the middle of cycle 50.
    sel   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    chk("pre_reset_running", {o_v, o_busy}, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {o_v, o_busy, o_done, o_pass}, 4'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {o_v, o_busy, o_done, o_pass}, 4'h0);
    run_test(1'b0, 16, 1'b1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
